dmem_ctrl: RTL and testbench

Data-memory controller sitting directly downstream of the pipelined CPU's MEM stage. It takes the CPU's address, store data, write strobe, read strobe and 3-bit `dm_ctrl` access type, performs byte-lane alignment and load sign/zero extension, and runs a request/grant/response handshake to a variable-latency data bus. It holds the CPU pipeline with a stall until each access completes.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_ctrl_if.sv | 21 ++
 rtl/dmem_lane_align.sv | 54 +++++
 rtl/dmem_ctrl.sv | 135 +++++++++++++
 tb/tb_dmem_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and the alignment helper for the data-memory controller.
// Alignment checking is only used when DMEM_MISALIGN_EXC_EN is defined.
package dmem_pkg;

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Byte accesses can never be misaligned; unknown encodings behave like words
  // everywhere else, but are not flagged here.
  function automatic logic misaligned(input logic [2:0] dm_ctrl, input logic [1:0] addr_lo);
    case (dm_ctrl)
      DM_HALF, DM_HALFU: misaligned = addr_lo[0];
      DM_WORD:           misaligned = |addr_lo;
      default:           misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/grant/response data-bus bundle between dmem_ctrl (master) and memory (slave).
interface dmem_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational store lane replication / byte-enable generation and load extract + extend.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  dm_ctrl,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Reads always fetch the full word; lane selection happens on the way back.
  always_comb begin
    be        = 4'b1111;
    lane_data = store_data;
    if (we) begin
      case (dm_ctrl)
        DM_BYTE, DM_BYTEU: begin
          be        = 4'b0001 << addr_lo;
          lane_data = {4{store_data[7:0]}};
        end
        DM_HALF, DM_HALFU: begin
          be        = addr_lo[1] ? 4'b1100 : 4'b0011;
          lane_data = {2{store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = load_word[7:0];
      2'd1:    byte_sel = load_word[15:8];
      2'd2:    byte_sel = load_word[23:16];
      default: byte_sel = load_word[31:24];
    endcase
    half_sel = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    case (dm_ctrl)
      DM_BYTE:  load_data = {{24{byte_sel[7]}}, byte_sel};
      DM_BYTEU: load_data = {24'd0, byte_sel};
      DM_HALF:  load_data = {{16{half_sel[15]}}, half_sel};
      DM_HALFU: load_data = {16'd0, half_sel};
      default:  load_data = load_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: latches a MEM-stage access, runs it on the bus and stalls the CPU.
// Define DMEM_MISALIGN_EXC_EN to abort misaligned accesses with cpu_misalign instead of truncating.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mem_r,
  input  logic              cpu_mem_w,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [2:0]        cpu_dm_ctrl,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              cpu_misalign,
  dmem_ctrl_if.master       bus
);

  state_t      state, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q, cnt_q;
  logic [2:0]  ctrl_q;
  logic        we_q, err_q;
  logic        access, timeout_hit, mis_now;
  logic [3:0]  be;
  logic [31:0] lane_data, load_data;

  assign access      = cpu_mem_r | cpu_mem_w;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q + 32'd1 == TIMEOUT);

`ifdef DMEM_MISALIGN_EXC_EN
  logic mis_q;
  assign mis_now      = misaligned(cpu_dm_ctrl, cpu_addr[1:0]);
  assign cpu_misalign = (state == ST_DONE) & mis_q;
`else
  assign mis_now      = 1'b0;
  assign cpu_misalign = 1'b0;
`endif

  dmem_lane_align u_align (
    .dm_ctrl    (ctrl_q),
    .addr_lo    (addr_q[1:0]),
    .we         (we_q),
    .store_data (wdata_q),
    .load_word  (bus.bus_rdata),
    .be         (be),
    .lane_data  (lane_data),
    .load_data  (load_data)
  );

  // Timeout wins over a grant in REQ, but a response that arrives in the last
  // WAIT cycle is still delivered as good data.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (access) state_d = mis_now ? ST_DONE : ST_REQ;
      ST_REQ: begin
        if (timeout_hit)      state_d = ST_DONE;
        else if (bus.bus_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.bus_rvalid)   state_d = ST_DONE;
        else if (timeout_hit) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      ctrl_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef DMEM_MISALIGN_EXC_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state <= state_d;
      case (state)
        ST_IDLE: begin
          if (access) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            ctrl_q  <= cpu_dm_ctrl;
            we_q    <= cpu_mem_w;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_MISALIGN_EXC_EN
            mis_q   <= mis_now;
            if (mis_now) rdata_q <= '0;
`endif
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + 32'd1;
          if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 32'd1;
          if (bus.bus_rvalid) begin
            rdata_q <= load_data;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus fields are only driven while requesting so an idle bus reads as all zeros.
  assign bus.bus_req   = (state == ST_REQ);
  assign bus.bus_we    = (state == ST_REQ) & we_q;
  assign bus.bus_addr  = (state == ST_REQ) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus.bus_be    = (state == ST_REQ) ? be : 4'b0000;
  assign bus.bus_wdata = (state == ST_REQ) ? lane_data : 32'd0;

  assign cpu_stall = ~reset & (((state == ST_IDLE) & access) | (state == ST_REQ) | (state == ST_WAIT));
  assign cpu_done  = (state == ST_DONE);
  assign cpu_err   = (state == ST_DONE) & err_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a scripted bus slave (TIMEOUT=8).
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mem_r, cpu_mem_w;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_dm_ctrl;
  logic        cpu_stall, cpu_done, cpu_err, cpu_misalign;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_mem_r    (cpu_mem_r),
    .cpu_mem_w    (cpu_mem_w),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_dm_ctrl  (cpu_dm_ctrl),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .cpu_done     (cpu_done),
    .cpu_err      (cpu_err),
    .cpu_misalign (cpu_misalign),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observations from the most recent access
  int          doneCyc, stallCyc, doneCnt;
  logic        reqSeen, reqWe, doneErr, doneMis, postBusy;
  logic [31:0] reqAddr, reqWdata, doneRdata;
  logic [3:0]  reqBe;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one access (held while stalled and through DONE), answers it with a
  // grant after gdly REQ cycles and rvalid rvdly cycles after the grant (0 = never),
  // then drops the strobes and fires a stray rvalid that must be ignored.
  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [2:0] c,
                               input logic [31:0] brd, input int gdly, input int rvdly);
    int   reqCnt, waitCnt;
    logic granted, finished;
    doneCyc = -1; stallCyc = 0; doneCnt = 0; reqSeen = 1'b0; postBusy = 1'b0;
    reqAddr = '0; reqWdata = '0; reqBe = '0; reqWe = 1'b0;
    doneRdata = '0; doneErr = 1'b0; doneMis = 1'b0;
    reqCnt = 0; waitCnt = 0; granted = 1'b0; finished = 1'b0;
    @(negedge clk);
    cpu_mem_r = r; cpu_mem_w = w; cpu_addr = a; cpu_wdata = wd; cpu_dm_ctrl = c;
    bus.bus_rdata = brd;
    for (int k = 0; k < 40 && !finished; k++) begin
      if (k > 0) @(negedge clk);
      bus.bus_gnt = 1'b0;
      bus.bus_rvalid = 1'b0;
      if (granted) begin
        waitCnt++;
        if (rvdly != 0 && waitCnt == rvdly) bus.bus_rvalid = 1'b1;
      end
      if (bus.bus_req) begin
        if (!reqSeen) begin
          reqAddr = bus.bus_addr; reqWdata = bus.bus_wdata; reqBe = bus.bus_be; reqWe = bus.bus_we;
        end
        reqSeen = 1'b1;
        if (reqCnt == gdly && !granted) begin
          bus.bus_gnt = 1'b1;
          granted = 1'b1;
        end
        reqCnt++;
      end
      #1;
      if (cpu_stall) stallCyc++;
      if (cpu_done) begin
        doneCnt++; doneCyc = k; doneRdata = cpu_rdata; doneErr = cpu_err; doneMis = cpu_misalign;
        finished = 1'b1;
      end
    end
    @(negedge clk);
    cpu_mem_r = 1'b0; cpu_mem_w = 1'b0;
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b1;
    #1;
    if (cpu_done) doneCnt++;
    postBusy = bus.bus_req | cpu_stall;
    @(negedge clk);
    bus.bus_rvalid = 1'b0;
    #1;
    if (cpu_done) doneCnt++;
    postBusy = postBusy | bus.bus_req | cpu_stall;
    checkOutput("rdata_held", cpu_rdata, doneRdata);
  endtask

  initial begin
    reset = 1'b1;
    cpu_mem_r = 1'b0; cpu_mem_w = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_dm_ctrl = '0;
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = '0;
    #12;
    checkOutput("rst_stall", cpu_stall, 0);
    checkOutput("rst_done", cpu_done, 0);
    checkOutput("rst_err", cpu_err, 0);
    checkOutput("rst_misalign", cpu_misalign, 0);
    checkOutput("rst_rdata", cpu_rdata, 0);
    checkOutput("rst_req", bus.bus_req, 0);
    checkOutput("rst_be", bus.bus_be, 0);
    checkOutput("rst_addr", bus.bus_addr, 0);
    @(negedge clk);
    reset = 1'b0;

    // sb with both strobes high: write, single lane, minimum latency
    applyStimulus(1'b1, 1'b1, 32'h103, 32'h0000_00A5, DM_BYTE, 32'h0, 0, 1);
    checkOutput("sb_be", reqBe, 4'b1000);
    checkOutput("sb_wdata", reqWdata, 32'hA5A5_A5A5);
    checkOutput("sb_addr", reqAddr, 32'h100);
    checkOutput("sb_we", reqWe, 1);
    checkOutput("sb_done_cyc", doneCyc, 3);
    checkOutput("sb_stall_cyc", stallCyc, 3);

    applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, DM_BYTE, 32'h12F0_3456, 0, 1);
    checkOutput("lb_rdata", doneRdata, 32'hFFFF_FFF0);
    checkOutput("lb_be", reqBe, 4'b1111);
    checkOutput("lb_we", reqWe, 0);
    applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, DM_BYTEU, 32'h12F0_3456, 0, 1);
    checkOutput("lbu_rdata", doneRdata, 32'h0000_00F0);
    applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, DM_HALF, 32'h12F0_3456, 0, 1);
    checkOutput("lh_rdata", doneRdata, 32'h0000_12F0);
    applyStimulus(1'b1, 1'b0, 32'h101, 32'h0, DM_BYTE, 32'h12F0_3456, 0, 1);
    checkOutput("lb1_rdata", doneRdata, 32'h0000_0034);
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, DM_HALF, 32'h1234_8001, 0, 1);
    checkOutput("lh0_rdata", doneRdata, 32'hFFFF_8001);
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, DM_HALFU, 32'h1234_8001, 0, 1);
    checkOutput("lhu0_rdata", doneRdata, 32'h0000_8001);

    applyStimulus(1'b0, 1'b1, 32'h102, 32'hDEAD_BEEF, DM_HALF, 32'h0, 0, 1);
    checkOutput("sh_be", reqBe, 4'b1100);
    checkOutput("sh_wdata", reqWdata, 32'hBEEF_BEEF);
    applyStimulus(1'b0, 1'b1, 32'h200, 32'h0123_4567, DM_WORD, 32'h0, 0, 1);
    checkOutput("sw_be", reqBe, 4'b1111);
    checkOutput("sw_wdata", reqWdata, 32'h0123_4567);
    checkOutput("sw_addr", reqAddr, 32'h200);

    // slow slave: grant after 4 REQ cycles, response 2 cycles after grant
    applyStimulus(1'b1, 1'b0, 32'h104, 32'h0, DM_WORD, 32'hCAFE_F00D, 4, 2);
    checkOutput("slow_done_cyc", doneCyc, 8);
    checkOutput("slow_stall_cyc", stallCyc, 8);
    checkOutput("slow_done_cnt", doneCnt, 1);
    checkOutput("slow_no_relaunch", postBusy, 0);
    checkOutput("slow_rdata", doneRdata, 32'hCAFE_F00D);
    checkOutput("slow_err", doneErr, 0);

    // no response: abort 8 cycles after entering REQ
    applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, DM_WORD, 32'h5555_5555, 0, 0);
    checkOutput("to_done_cyc", doneCyc, 9);
    checkOutput("to_err", doneErr, 1);
    checkOutput("to_rdata", doneRdata, 0);
    checkOutput("to_done_cnt", doneCnt, 1);

    applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, DM_WORD, 32'h8765_4321, 0, 1);
`ifdef DMEM_MISALIGN_EXC_EN
    checkOutput("mis_req_seen", reqSeen, 0);
    checkOutput("mis_done_cyc", doneCyc, 1);
    checkOutput("mis_flag", doneMis, 1);
    checkOutput("mis_rdata", doneRdata, 0);
`else
    checkOutput("mis_req_seen", reqSeen, 1);
    checkOutput("mis_addr", reqAddr, 32'h100);
    checkOutput("mis_flag", doneMis, 0);
    checkOutput("mis_rdata", doneRdata, 32'h8765_4321);
`endif

    // reset while waiting for a response
    @(negedge clk);
    cpu_mem_r = 1'b1; cpu_addr = 32'h400; cpu_dm_ctrl = DM_WORD;
    @(negedge clk);
    bus.bus_gnt = 1'b1;
    @(negedge clk);
    bus.bus_gnt = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("wait_stall", cpu_stall, 1);
    reset = 1'b1;
    #1;
    checkOutput("rstw_req", bus.bus_req, 0);
    checkOutput("rstw_stall", cpu_stall, 0);
    checkOutput("rstw_done", cpu_done, 0);
    @(negedge clk);
    reset = 1'b0; cpu_mem_r = 1'b0;
    #1;
    checkOutput("rstw_idle_stall", cpu_stall, 0);
    @(negedge clk);
    #1;
    checkOutput("rstw_idle_req", bus.bus_req, 0);
    checkOutput("rstw_idle_done", cpu_done, 0);

    applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, DM_BYTEU, 32'h0000_0080, 0, 1);
    checkOutput("post_rst_rdata", doneRdata, 32'h0000_0080);
    checkOutput("post_rst_done_cyc", doneCyc, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
